// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT bit-reverse reorder buffer.
package fft_pkg;
  localparam int MAX_LOG2 = 12;

  typedef enum logic {W_IDLE, W_FILL}  wr_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

  function automatic int fft_len(input int log2);
    return 1 << log2;
  endfunction

  // Reverse the low 'bits' bits of v; upper bits of the result are zero.
  function automatic logic [MAX_LOG2-1:0] bitrev(input logic [MAX_LOG2-1:0] v, input int bits);
    logic [MAX_LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2; i++)
      if (i < bits) r[i] = v[bits-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle: bit-reversed input side, natural-order output side.
interface fft_bitrev_reorder_if #(parameter int DATA_WIDTH = 16);
  logic                  sig_start_i;
  logic                  sig_vld_i;
  logic [DATA_WIDTH-1:0] sig_real_i;
  logic [DATA_WIDTH-1:0] sig_imag_i;
  logic                  sig_start_o;
  logic                  sig_vld_o;
  logic [DATA_WIDTH-1:0] sig_real_o;
  logic [DATA_WIDTH-1:0] sig_imag_o;
  logic                  frame_err_o;

  modport master (output sig_start_i, sig_vld_i, sig_real_i, sig_imag_i,
                  input  sig_start_o, sig_vld_o, sig_real_o, sig_imag_o, frame_err_o);
  modport slave  (input  sig_start_i, sig_vld_i, sig_real_i, sig_imag_i,
                  output sig_start_o, sig_vld_o, sig_real_o, sig_imag_o, frame_err_o);
endinterface

// File: rtl/fft_pingpong_ram.sv
// Simple dual-port RAM, two banks selected by the address MSB, registered read.
module fft_pingpong_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: fills one bank in bit-reversed order while the other drains naturally.
module fft_bitrev_reorder import fft_pkg::*; #(
  parameter int DATA_WIDTH   = 16,
  parameter int FFT_LEN_LOG2 = 6
) (
  input logic                 clk,
  input logic                 rst,
  fft_bitrev_reorder_if.slave bus
);
  localparam int AW = FFT_LEN_LOG2;
  localparam int DW = DATA_WIDTH;

  wr_state_t       wr_state, wr_state_n;
  rd_state_t       rd_state, rd_state_n;
  logic [AW-1:0]   wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n;
  logic            wr_bank, wr_bank_n, rd_bank, rd_bank_n;
  logic [1:0]      full, set_full, clr_full;
  logic            we, re, rd_first, frame_err, frame_err_n;
  logic [AW:0]     waddr, raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]      vld_pipe, sop_pipe;
  logic [DW-1:0]   real_q, imag_q;
  logic            acc_start;

  assign acc_start = bus.sig_vld_i && bus.sig_start_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      rd_state <= rd_state_n;
      wr_cnt   <= wr_cnt_n;
      rd_cnt   <= rd_cnt_n;
      wr_bank  <= wr_bank_n;
      rd_bank  <= rd_bank_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    wr_state_n  = wr_state;
    wr_cnt_n    = wr_cnt;
    wr_bank_n   = wr_bank;
    we          = 1'b0;
    waddr       = {wr_bank, {AW{1'b0}}};
    set_full    = '0;
    frame_err_n = 1'b0;
    case (wr_state)
      W_IDLE: if (acc_start) begin
        we         = 1'b1;
        wr_cnt_n   = AW'(1);
        wr_state_n = W_FILL;
      end
      W_FILL: begin
        if (acc_start) begin
          // Restart in the same bank; the partial frame is simply overwritten.
          we          = 1'b1;
          frame_err_n = 1'b1;
          wr_cnt_n    = AW'(1);
        end else if (bus.sig_vld_i) begin
          we    = 1'b1;
          waddr = {wr_bank, AW'(bitrev(MAX_LOG2'(wr_cnt), FFT_LEN_LOG2))};
          if (&wr_cnt) begin
            set_full[wr_bank] = 1'b1;
            wr_bank_n  = ~wr_bank;
            wr_cnt_n   = '0;
            wr_state_n = W_IDLE;
          end else begin
            wr_cnt_n = wr_cnt + 1'b1;
          end
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  // Address 0 is issued straight out of R_IDLE so the drain starts the cycle after the flag sets.
  always_comb begin
    rd_state_n = rd_state;
    rd_cnt_n   = rd_cnt;
    rd_bank_n  = rd_bank;
    re         = 1'b0;
    rd_first   = 1'b0;
    raddr      = {rd_bank, rd_cnt};
    clr_full   = '0;
    case (rd_state)
      R_IDLE: if (full[rd_bank]) begin
        re         = 1'b1;
        rd_first   = 1'b1;
        raddr      = {rd_bank, {AW{1'b0}}};
        rd_cnt_n   = AW'(1);
        rd_state_n = R_DRAIN;
      end
      R_DRAIN: begin
        re = 1'b1;
        if (&rd_cnt) begin
          clr_full[rd_bank] = 1'b1;
          rd_bank_n  = ~rd_bank;
          rd_cnt_n   = '0;
          rd_state_n = R_IDLE;
        end else begin
          rd_cnt_n = rd_cnt + 1'b1;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= '0;
    else
      for (int b = 0; b < 2; b++)
        if (set_full[b])      full[b] <= 1'b1;
        else if (clr_full[b]) full[b] <= 1'b0;
  end

  fft_pingpong_ram #(.AW(AW + 1), .DW(2 * DW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata ({bus.sig_real_i, bus.sig_imag_i}),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      sop_pipe <= '0;
      real_q   <= '0;
      imag_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], re};
      sop_pipe <= {sop_pipe[0], rd_first};
      real_q   <= vld_pipe[0] ? rdata[2*DW-1:DW] : '0;
      imag_q   <= vld_pipe[0] ? rdata[DW-1:0]    : '0;
    end
  end

  assign bus.sig_vld_o   = vld_pipe[1];
  assign bus.sig_start_o = sop_pipe[1];
  assign bus.sig_real_o  = real_q;
  assign bus.sig_imag_o  = imag_q;
  assign bus.frame_err_o = frame_err;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) acc_start |-> !full[wr_bank]);
endmodule
